// File: rtl/fmap_streamer.sv
// Raster-stream source: reads a WIDTH x HEIGHT feature map from a frame RAM
// with 1-cycle read latency and emits it row-major as a valid/ready stream
// with sof/eol/eof markers. A 2-entry skid buffer absorbs the read latency
// under backpressure; the in-flight return is forwarded straight to the
// output when the buffer is empty so the first beat appears one cycle after
// its read.
module fmap_streamer #(
  parameter int WIDTH     = 28,
  parameter int HEIGHT    = 28,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_BITS-1:0] base_addr,
  output logic                 mem_rd_en,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [DATA_BITS-1:0] mem_rd_data,
  input  logic                 ready_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 sof,
  output logic                 eol,
  output logic                 eof,
  output logic                 busy,
  output logic                 done
);

  localparam int XB = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YB = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XB-1:0] X_LAST = XB'(WIDTH - 1);
  localparam logic [YB-1:0] Y_LAST = YB'(HEIGHT - 1);
  // Beat entry layout: {sof, eol, eof, data}
  localparam int EB = DATA_BITS + 3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t               r_state, w_state_next;
  logic [ADDR_BITS-1:0] r_base, r_idx;
  logic [XB-1:0]        r_x;
  logic [YB-1:0]        r_y;
  logic                 r_busy, r_done;
  logic                 r_inf_valid;
  logic [2:0]           r_inf_tag;
  logic [EB-1:0]        r_buf [0:1];
  logic                 r_wr_ptr, r_rd_ptr;
  logic [1:0]           r_cnt;

  logic          w_abort, w_start_ok, w_rd_last, w_use_buf, w_valid;
  logic          w_xfer, w_push, w_pop, w_last_xfer;
  logic [2:0]    w_rd_tag, w_occ;
  logic [EB-1:0] w_head;

  // Abort only matters once a frame is under way
  assign w_abort    = abort && (r_state != S_IDLE);
  // The done cycle is still busy, so a start there is ignored
  assign w_start_ok = start && (r_state == S_IDLE) && !r_busy;

  assign w_rd_last = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_rd_tag  = {(r_x == '0) && (r_y == '0), r_x == X_LAST, w_rd_last};

  // Oldest beat is the buffer head; with an empty buffer the RAM return itself
  assign w_use_buf   = (r_cnt != 2'd0);
  assign w_head      = w_use_buf ? r_buf[r_rd_ptr] : {r_inf_tag, mem_rd_data};
  assign w_valid     = w_use_buf || r_inf_valid;
  assign w_xfer      = w_valid && ready_in;
  assign w_last_xfer = w_xfer && w_head[DATA_BITS];
  // Beats that will still be held after this cycle's transfer
  assign w_occ  = {1'b0, r_cnt} + {2'b00, r_inf_valid} - {2'b00, w_xfer};
  // A return is buffered unless it is consumed directly this cycle
  assign w_push = r_inf_valid && !(!w_use_buf && w_xfer);
  assign w_pop  = w_xfer && w_use_buf;

  assign valid_out = w_valid;
  assign data_out  = w_valid ? w_head[DATA_BITS-1:0] : '0;
  assign sof       = w_valid && w_head[DATA_BITS+2];
  assign eol       = w_valid && w_head[DATA_BITS+1];
  assign eof       = w_valid && w_head[DATA_BITS];
  assign busy      = r_busy;
  assign done      = r_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_next = S_RUN;
      S_RUN:   if (w_abort) w_state_next = S_IDLE;
               else if (mem_rd_en && w_rd_last) w_state_next = S_DRAIN;
      S_DRAIN: if (w_abort || w_last_xfer) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Read issue: never more than two beats held or in flight
  always_comb begin
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    if (r_state == S_RUN && !w_abort && w_occ < 3'd2) begin
      mem_rd_en = 1'b1;
      mem_addr  = r_base + r_idx;
    end
  end

  // Read-side raster counters and base address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
      r_idx  <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (w_start_ok) begin
      r_base <= base_addr;
      r_idx  <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (mem_rd_en) begin
      r_idx <= r_idx + ADDR_BITS'(1);
      if (r_x == X_LAST) begin
        r_x <= '0;
        r_y <= r_y + YB'(1);
      end else begin
        r_x <= r_x + XB'(1);
      end
    end
  end

  // Busy spans start acceptance through the done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last_xfer && !w_abort && (r_state != S_IDLE);
      if (w_start_ok)           r_busy <= 1'b1;
      else if (w_abort || r_done) r_busy <= 1'b0;
    end
  end

  // In-flight stage: tags follow the read until its data returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inf_valid <= 1'b0;
      r_inf_tag   <= '0;
    end else if (w_abort) begin
      r_inf_valid <= 1'b0;
      r_inf_tag   <= '0;
    end else begin
      r_inf_valid <= mem_rd_en;
      r_inf_tag   <= w_rd_tag;
    end
  end

  // Skid buffer occupancy and pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (w_abort) begin
      r_cnt    <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      // Skid buffer entry gi captures the RAM return with its tags
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                              r_buf[gi] <= '0;
        else if (w_push && r_wr_ptr == 1'(gi)) r_buf[gi] <= {r_inf_tag, mem_rd_data};
      end
    end
  endgenerate

endmodule

// File: tb/tb_fmap_streamer.sv
// Directed bench for fmap_streamer on a 4x3 frame: a scoreboard queue holds
// the expected beats pushed at each accepted start and is popped on every
// transfer; cycle-exact checks cover latency, markers and control.
module tb_fmap_streamer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DB = 8;
  localparam int AB = 10;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ready_in = 1'b0;
  logic [AB-1:0] base_addr = '0;
  logic          mem_rd_en;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_rd_data = '0;
  logic [DB-1:0] data_out;
  logic          valid_out, sof, eol, eof, busy, done;

  fmap_streamer #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Frame RAM model: RAM[a] = a[7:0], one-cycle read latency
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr[7:0];

  int          checks = 0;
  int          failures = 0;
  logic [10:0] sb[$];
  int          outst = 0;
  int          xfers = 0;
  int          dones = 0;
  logic        held_v = 1'b0;
  logic [10:0] held = '0;
  logic        prev_abort = 1'b0;
  logic        armed;
  int          ab_c, x0, d0, reads;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [AB-1:0] b);
    logic [AB-1:0] a;
    logic s, l, f;
    for (int i = 0; i < N; i++) begin
      a = b + AB'(i);
      s = (i == 0);
      l = ((i % W) == W - 1);
      f = (i == N - 1);
      sb.push_back({a[7:0], s, l, f});
    end
  endtask

  // Per-cycle monitor: hold stability, outstanding-read bound, scoreboard
  task automatic mon();
    logic [10:0] cur, e;
    logic x;
    if (rst) begin
      outst = 0;
      held_v = 1'b0;
      prev_abort = 1'b0;
      return;
    end
    cur = {data_out, sof, eol, eof};
    x = valid_out && ready_in;
    if (held_v && !prev_abort) begin
      check("hold_valid", valid_out, 1);
      check("hold_beat", cur, held);
    end
    if (abort && busy) outst = 0;
    else begin
      outst = outst + (mem_rd_en ? 1 : 0) - (x ? 1 : 0);
      if (mem_rd_en) check("outstanding_le2", (outst <= 2), 1);
    end
    if (done) dones++;
    if (x) begin
      xfers++;
      check("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("beat", cur, e);
      end
      $display("beat t=%0t data=%0d sof=%0b eol=%0b eof=%0b", $time, data_out, sof, eol, eof);
    end
    held_v = valid_out && !ready_in;
    held = cur;
    prev_abort = abort;
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    mon();
  endtask

  initial begin
    // Reset values, then reset asserted mid-frame with random inputs
    repeat (3) begin go(); look(); end
    go(); rst = 1'b0; look();
    go(); start = 1'b1; base_addr = 10'd16; ready_in = 1'b1; push_frame(10'd16); look();
    go(); start = 1'b0; look();
    go(); look();
    go(); look();
    go();
    #2;
    rst = 1'b1;
    start = 1'($urandom_range(0, 1));
    abort = 1'($urandom_range(0, 1));
    base_addr = AB'($urandom);
    ready_in = 1'($urandom_range(0, 1));
    #1;
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_flags", {sof, eol, eof}, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    look();
    go(); look();
    go(); rst = 1'b0; start = 1'b0; abort = 1'b0; ready_in = 1'b1; sb.delete(); look();
    for (int c = 0; c < 4; c++) begin
      go(); look();
      check("idle_rd_en", mem_rd_en, 0);
      check("idle_busy", busy, 0);
      check("idle_valid", valid_out, 0);
    end

    // Nominal frame, ready high, cycle-exact
    d0 = dones;
    for (int c = 0; c < 16; c++) begin
      go(); start = (c == 0); base_addr = 10'd16; ready_in = 1'b1;
      if (c == 0) push_frame(10'd16);
      look();
      check("nom_valid", valid_out, (c >= 2 && c <= 13));
      check("nom_busy", busy, (c >= 1 && c <= 14));
      check("nom_done", done, (c == 14));
      check("nom_rd_en", mem_rd_en, (c >= 1 && c <= 12));
      if (c >= 2 && c <= 13) begin
        check("nom_data", data_out, 16 + c - 2);
        check("nom_sof", sof, (c == 2));
        check("nom_eol", eol, (c == 5 || c == 9 || c == 13));
        check("nom_eof", eof, (c == 13));
      end
    end
    check("nom_sb_empty", sb.size(), 0);
    check("nom_dones", dones - d0, 1);

    // Backpressure: ready low for 5 cycles while beat 18 is presented
    x0 = xfers; d0 = dones;
    for (int c = 0; c < 31; c++) begin
      go(); start = (c == 0); base_addr = 10'd16; ready_in = !(c >= 4 && c <= 8);
      if (c == 0) push_frame(10'd16);
      look();
      if (c >= 4 && c <= 8) check("bp_hold18", {valid_out, data_out}, {1'b1, 8'd18});
    end
    check("bp_xfers", xfers - x0, N);
    check("bp_sb_empty", sb.size(), 0);
    check("bp_dones", dones - d0, 1);

    // Stall from the first beat, plus a start pulse mid-frame
    x0 = xfers; d0 = dones; reads = 0;
    for (int c = 0; c < 41; c++) begin
      go(); start = (c == 0 || c == 6); base_addr = (c == 6) ? 10'd500 : 10'd100;
      ready_in = (c >= 8);
      if (c == 0) push_frame(10'd100);
      look();
      if (c >= 1 && c <= 7 && mem_rd_en) reads++;
      if (c >= 3 && c <= 7) check("stall_rd_low", mem_rd_en, 0);
      if (c == 7) check("stall_head", {valid_out, data_out}, {1'b1, 8'd100});
    end
    check("stall_reads", reads, 2);
    check("stall_xfers", xfers - x0, N);
    check("stall_sb_empty", sb.size(), 0);
    check("stall_dones", dones - d0, 1);

    // Start on the done cycle is ignored; start on the next cycle is taken
    x0 = xfers; d0 = dones;
    for (int c = 0; c < 33; c++) begin
      go(); start = (c == 0 || c == 14 || c == 15); ready_in = 1'b1;
      base_addr = (c < 14) ? 10'd200 : ((c == 14) ? 10'd250 : 10'd300);
      if (c == 0) push_frame(10'd200);
      if (c == 15) push_frame(10'd300);
      look();
      if (c == 14) check("b2b_done1", {done, busy}, 2'b11);
      if (c == 16) check("b2b_busy2", busy, 1);
      if (c == 17) check("b2b_first2", data_out, 8'(300));
      if (c == 29) check("b2b_done2", done, 1);
    end
    check("b2b_xfers", xfers - x0, 2 * N);
    check("b2b_sb_empty", sb.size(), 0);
    check("b2b_dones", dones - d0, 2);

    // Address wrap from base 1020
    for (int c = 0; c < 16; c++) begin
      go(); start = (c == 0); base_addr = 10'd1020; ready_in = 1'b1;
      if (c == 0) push_frame(10'd1020);
      look();
      if (c >= 1 && c <= 12) check("wrap_addr", {mem_rd_en, mem_addr}, {1'b1, AB'(1020 + c - 1)});
    end
    check("wrap_sb_empty", sb.size(), 0);

    // Abort while beat 21 is held, ready toggling
    ab_c = -1; armed = 1'b0; d0 = dones;
    for (int c = 0; c < 40; c++) begin
      go(); start = (c == 0); base_addr = 10'd16; ready_in = (c % 2 == 1);
      abort = armed && (ab_c < 0);
      if (c == 0) push_frame(10'd16);
      if (ab_c >= 0 && c == ab_c + 1) sb.delete();
      if (abort) ab_c = c;
      look();
      armed = valid_out && (data_out == 8'd21) && !ready_in;
      if (ab_c >= 0 && c > ab_c && c <= ab_c + 6) begin
        check("abort_valid", valid_out, 0);
        check("abort_rd_en", mem_rd_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
      end
    end
    check("abort_seen", (ab_c >= 0), 1);
    check("abort_no_done", dones - d0, 0);

    // Restart after abort streams from base again
    x0 = xfers; d0 = dones;
    for (int c = 0; c < 16; c++) begin
      go(); start = (c == 0); abort = 1'b0; base_addr = 10'd16; ready_in = 1'b1;
      if (c == 0) push_frame(10'd16);
      look();
      if (c == 2) check("restart_first", {valid_out, sof, data_out}, {2'b11, 8'd16});
    end
    check("restart_xfers", xfers - x0, N);
    check("restart_sb_empty", sb.size(), 0);
    check("restart_dones", dones - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
